// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button conditioning path.
package button_pkg;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_LONG_CYCLES     = 64;
    localparam int unsigned DEF_REPEAT_CYCLES   = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        HELD     = 3'd2,
        LONG     = 3'd3,
        DB_REL   = 3'd4
    } state_e;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/button_conditioner_sync_ff.sv
// Parameterized-depth synchronizer for a single asynchronous input.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; oldest sample is the output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner: synchronizer, counter debouncer and
// press/release/long-press/auto-repeat state machine with registered outputs.
// The repeat pulse output is named repeat_p because `repeat` is a reserved word.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_p,
    output logic long_press,
    output logic repeat_p
);

    localparam int unsigned MAX_P = max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    logic s;

    state_e        state_q,     state_d;
    logic [CW-1:0] db_cnt_q,    db_cnt_d;
    logic [CW-1:0] hold_cnt_q,  hold_cnt_d;
    logic [CW-1:0] rep_cnt_q,   rep_cnt_d;
    logic          long_seen_q, long_seen_d;
    logic          level_q,     level_d;
    logic          press_q,     press_d;
    logic          release_q,   release_d;
    logic          long_q,      long_d;
    logic          repeat_q,    repeat_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (btn_raw),
        .q_o    (s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            long_seen_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            long_seen_q <= long_seen_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    // Next-state, counter updates and pulse generation; one transition per cycle
    // keeps the pulses mutually exclusive.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        long_seen_d = long_seen_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (s) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = HELD;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = sat_inc(db_cnt_q);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d     = DB_REL;
                    db_cnt_d    = '0;
                    long_seen_d = 1'b0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    state_d   = LONG;
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end
            LONG: begin
                if (!s) begin
                    state_d     = DB_REL;
                    db_cnt_d    = '0;
                    long_seen_d = 1'b1;
                end else if (rep_cnt_q == REP_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = sat_inc(rep_cnt_q);
                end
            end
            DB_REL: begin
                // A release bounce resumes the hold/repeat counters where they stopped.
                if (s) begin
                    state_d = long_seen_q ? LONG : HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    db_cnt_d = sat_inc(db_cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    assign level      = level_q;
    assign press      = press_q;
    assign release_p  = release_q;
    assign long_press = long_q;
    assign repeat_p   = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/long/repeat counts.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int unsigned SYNC_STAGES     = 2;
    localparam int unsigned DEBOUNCE_CYCLES = 4;
    localparam int unsigned LONG_CYCLES     = 8;
    localparam int unsigned REPEAT_CYCLES   = 3;

    logic clk;
    logic rst;
    logic btn_raw;
    logic level;
    logic press;
    logic release_p;
    logic long_press;
    logic repeat_p;

    int n_cmp = 0;
    int n_bad = 0;

    button_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .level      (level),
        .press      (press),
        .release_p  (release_p),
        .long_press (long_press),
        .repeat_p   (repeat_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected vector order: {level, press, release_p, long_press, repeat_p}
    task automatic chk(input string tag, input int idx, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {level, press, release_p, long_press, repeat_p};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %b expected %b (lvl,prs,rel,lng,rep)", tag, idx, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        btn_raw = 1'b0;

        // 1. Reset held while the raw input toggles.
        for (int i = 0; i < 5; i++) begin
            btn_raw = i[0];
            tick();
            chk("reset", i, 5'b00000);
        end
        n_cmp++;
        assert (dut.state_q === IDLE) else begin
            n_bad++;
            $error("FAIL reset_state: observed %0d expected %0d", dut.state_q, IDLE);
        end
        btn_raw = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle", i, 5'b00000);
        end

        // 2. Clean press at edge 0, then clean release.
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("press", i, {i >= 6, i == 6, 1'b0, 1'b0, 1'b0});
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("release", i, {i < 6, 1'b0, i == 6, 1'b0, 1'b0});
        end

        // 3. Bounce: 2 cycles high / 2 cycles low never reaches acceptance.
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2) == 0;
            tick();
            chk("bounce", i, 5'b00000);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bounce_low", i, 5'b00000);
        end

        // 4/5. Long hold with repeats, 2-cycle low glitch at edges 31-32,
        //      clean fall at edge 46. The glitch stalls rep_cnt for exactly one
        //      repeat period, so the pulse at 35 is lost but the grid stays put.
        for (int i = 0; i < 56; i++) begin
            btn_raw = (i <= 45) && (i != 31) && (i != 32);
            tick();
            chk("hold", i, {(i >= 6) && (i < 52),
                            i == 6,
                            i == 52,
                            i == 14,
                            (i >= 17) && ((i - 17) % 3 == 0) && (i != 35) && (i <= 47)});
        end

        // 6. Async reset while in LONG, then a fresh press after release of reset.
        btn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rehold", i, {i >= 6, i == 6, 1'b0, i == 14, i == 17});
        end
        rst = 1'b0;
        #1;
        chk("async_rst", 0, 5'b00000);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("in_rst", i, 5'b00000);
        end
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("post_rst", i, {i >= 6, i == 6, 1'b0, 1'b0, 1'b0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
